// File: rtl/vending_dispense_ctrl.sv
// Dispense stage behind the vending FSM: runs the product motor, supervises the
// drop sensor, pulses the coin-return solenoid and keeps stock/sales bookkeeping.
module vending_dispense_ctrl #(
  parameter int unsigned MOTOR_CYCLES = 8,
  parameter int unsigned DROP_TIMEOUT = 32,
  parameter int unsigned EJECT_CYCLES = 4,
  parameter int unsigned STOCK_INIT   = 10,
  parameter int unsigned STOCK_W      = 8,
  parameter int unsigned PEND_MAX     = 3
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               sell,
  input  logic [1:0]         change,
  input  logic               drop_det,
  input  logic               restock,
  output logic               motor_on,
  output logic               coin_eject,
  output logic               busy,
  output logic               sold_out,
  output logic               fault,
  output logic               ovf,
  output logic [STOCK_W-1:0] stock,
  output logic [15:0]        sale_cnt
);

  localparam int unsigned TMR_MAX0 = (MOTOR_CYCLES > EJECT_CYCLES) ? MOTOR_CYCLES : EJECT_CYCLES;
  localparam int unsigned TMR_MAX  = (TMR_MAX0 > DROP_TIMEOUT) ? TMR_MAX0 : DROP_TIMEOUT;
  localparam int unsigned TMR_W    = $clog2(TMR_MAX + 1);
  localparam int unsigned PEND_W   = $clog2(PEND_MAX + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DISPENSE  = 3'd1,
    WAIT_DROP = 3'd2,
    EJECT_HI  = 3'd3,
    EJECT_LO  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [PEND_W-1:0]  sale_pend_q, sale_pend_d;
  logic [3:0]         chg_pend_q, chg_pend_d;
  logic               drop_seen_q;
  logic [STOCK_W-1:0] stock_q;
  logic [15:0]        sale_cnt_q;
  logic               fault_q, ovf_q;

  logic       sale_take, refund, chg_take, success, timeout;
  logic       sell_ok, chg_sat;
  logic [5:0] chg_sum;

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    sale_take = 1'b0;
    refund    = 1'b0;
    chg_take  = 1'b0;
    success   = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (sale_pend_q != '0) begin
          sale_take = 1'b1;
          if (stock_q != '0) state_d = DISPENSE;
          else               refund  = 1'b1;
        end else if (chg_pend_q != 4'd0) begin
          state_d = EJECT_HI;
        end
      end
      DISPENSE: begin
        if (tmr_q == TMR_W'(MOTOR_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = WAIT_DROP;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      WAIT_DROP: begin
        if (drop_seen_q || drop_det) begin
          success = 1'b1;
          tmr_d   = '0;
          state_d = IDLE;
        end else if (tmr_q == TMR_W'(DROP_TIMEOUT - 1)) begin
          timeout = 1'b1;
          tmr_d   = '0;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      EJECT_HI: begin
        if (tmr_q == TMR_W'(EJECT_CYCLES - 1)) begin
          tmr_d    = '0;
          chg_take = 1'b1;
          state_d  = EJECT_LO;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      EJECT_LO: begin
        if (tmr_q == TMR_W'(EJECT_CYCLES - 1)) begin
          tmr_d = '0;
          // Pending sales take precedence over the remaining coins.
          if (chg_pend_q != 4'd0 && sale_pend_q == '0) state_d = EJECT_HI;
          else                                         state_d = IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture and consume are summed so a same-cycle request and service net out.
  always_comb begin
    sell_ok     = sell && (sale_pend_q != PEND_W'(PEND_MAX));
    sale_pend_d = sale_pend_q + PEND_W'(sell_ok) - PEND_W'(sale_take);
    chg_sum     = 6'(chg_pend_q) + 6'(change) + ((refund || timeout) ? 6'd4 : 6'd0)
                  - 6'(chg_take);
    chg_sat     = chg_sum > 6'd15;
    chg_pend_d  = chg_sat ? 4'd15 : chg_sum[3:0];
  end

  // NOTE: sequential state is written only with non-blocking assignments so all
  // registers update together from pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      sale_pend_q <= '0;
      chg_pend_q  <= 4'd0;
      drop_seen_q <= 1'b0;
      motor_on    <= 1'b0;
      coin_eject  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      sale_pend_q <= sale_pend_d;
      chg_pend_q  <= chg_pend_d;
      drop_seen_q <= (state_q == DISPENSE) ? (drop_seen_q | drop_det) : 1'b0;
      motor_on    <= (state_d == DISPENSE);
      coin_eject  <= (state_d == EJECT_HI);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stock_q    <= STOCK_W'(STOCK_INIT);
      sale_cnt_q <= 16'd0;
      fault_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (restock)      stock_q <= STOCK_W'(STOCK_INIT);
      else if (success) stock_q <= stock_q - STOCK_W'(1);
      if (success) sale_cnt_q <= sale_cnt_q + 16'd1;
      // A new event in the restock cycle is kept rather than lost.
      if (timeout)      fault_q <= 1'b1;
      else if (restock) fault_q <= 1'b0;
      if ((sell && !sell_ok) || chg_sat) ovf_q <= 1'b1;
      else if (restock)                  ovf_q <= 1'b0;
    end
  end

  assign busy     = (state_q != IDLE) || (sale_pend_q != '0) || (chg_pend_q != 4'd0);
  assign sold_out = (stock_q == '0);
  assign stock    = stock_q;
  assign sale_cnt = sale_cnt_q;
  assign fault    = fault_q;
  assign ovf      = ovf_q;

endmodule
